// File: rtl/pc_fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the branch/ALU stage, instruction memory and decode.
// master = the fetch sequencer, slave = its surroundings (bench or neighbouring stages).
interface pc_fetch_sequencer_if;
  logic        Branch;
  logic        Unconditional;
  logic        ALUZero;
  logic        ZorNZ;
  logic [63:0] BranchTarget;

  // IMemReq/IMemAddr hold until a cycle with IMemAck; InstrValid/Instr/InstrPC hold until
  // a cycle with InstrReady; a transfer happens only when both sides are high in one cycle.
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;

  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady;

  logic [63:0] PC;
  logic        Redirect;
  logic        Fault;
  logic [1:0]  State;

  modport master (
    input  Branch, Unconditional, ALUZero, ZorNZ, BranchTarget,
    input  IMemAck, IMemData, InstrReady,
    output IMemReq, IMemAddr, InstrValid, Instr, InstrPC, PC, Redirect, Fault, State
  );

  modport slave (
    output Branch, Unconditional, ALUZero, ZorNZ, BranchTarget,
    output IMemAck, IMemData, InstrReady,
    input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC, PC, Redirect, Fault, State
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: single-outstanding imem requests, instruction FIFO, branch redirect.
// Optional misaligned-target fault/halt enabled with `define PC_ALIGN_CHECK_EN.
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input logic                  Clk,
  input logic                  Reset,
  pc_fetch_sequencer_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

  state_t        state;
  logic [63:0]   pc;
  logic          req_q, valid_q, redirect_q, fault;
  logic [63:0]   addr_q, instr_pc_q;
  logic [31:0]   instr_q;
  logic [31:0]   mem_data [BUF_DEPTH];
  logic [63:0]   mem_pc   [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next;
  logic          taken, kill, accept, bad, fault_next, ack, push, pop;
  logic [63:0]   target;
  logic [31:0]   head_data;
  logic [63:0]   head_pc;

  assign taken = bus.Unconditional | (bus.Branch & (bus.ALUZero == bus.ZorNZ));

`ifdef PC_ALIGN_CHECK_EN
  assign target = bus.BranchTarget;
  assign bad    = bus.BranchTarget[1:0] != 2'b00;
  assign kill   = taken && (state != HALT);
  // Once faulted, further branches only flush; the PC stays frozen.
  assign accept = kill && !bad && !fault;
`else
  assign target = bus.BranchTarget & ~64'h3;
  assign bad    = 1'b0;
  assign kill   = taken;
  assign accept = taken;
  assign fault  = 1'b0;
`endif

  assign fault_next = fault | (kill & bad);
  assign ack        = bus.IMemAck && req_q;
  assign push       = (state == REQ) && ack && !kill;
  assign pop        = valid_q && bus.InstrReady && !kill;
  assign count_next = kill ? '0 : count + CW'(push) - CW'(pop);

  // Next head bypasses the array when the FIFO is (or drains to) empty in the pushing cycle.
  always_comb begin
    rd_ptr_next = rd_ptr + PW'(pop);
    if (push && (count == CW'(pop))) begin
      head_data = bus.IMemData;
      head_pc   = addr_q;
    end else begin
      head_data = mem_data[rd_ptr_next];
      head_pc   = mem_pc[rd_ptr_next];
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.IMemData;
      mem_pc[wr_ptr]   <= addr_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      redirect_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault      <= 1'b0;
`endif
    end else begin
      redirect_q <= accept;
`ifdef PC_ALIGN_CHECK_EN
      fault      <= fault_next;
`endif
      count   <= count_next;
      valid_q <= count_next != '0;
      if (count_next != '0) begin
        instr_q    <= head_data;
        instr_pc_q <= head_pc;
      end
      if (kill) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr_next;
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end

      if (accept) pc <= target;

      case (state)
        IDLE: begin
          if (accept) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= target;
          end else if (fault_next) begin
            state <= HALT;
          end else if (count_next < DEPTH_C) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= pc;
          end
        end
        REQ: begin
          if (kill) begin
            if (!ack) begin
              state <= DRAIN;
            end else if (fault_next) begin
              state <= HALT;
              req_q <= 1'b0;
            end else begin
              addr_q <= target;
            end
          end else if (ack) begin
            pc <= pc + 64'd4;
            if (count_next < DEPTH_C) begin
              addr_q <= pc + 64'd4;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (ack) begin
            if (fault_next) begin
              state <= HALT;
              req_q <= 1'b0;
            end else begin
              state  <= REQ;
              addr_q <= accept ? target : pc;
            end
          end
        end
        default: begin
          state <= HALT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IMemReq    = req_q;
  assign bus.IMemAddr   = addr_q;
  assign bus.InstrValid = valid_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrPC    = instr_pc_q;
  assign bus.PC         = pc;
  assign bus.Redirect   = redirect_q;
  assign bus.Fault      = fault;
  assign bus.State      = state;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: streaming, backpressure, redirects, async reset,
// misaligned targets. Memory data is a fixed function of the byte address.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  pc_fetch_sequencer_if bus();

  pc_fetch_sequencer dut (.Clk(clk), .Reset(rst), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_drive(input bit en);
    bus.IMemAck  = en && bus.IMemReq;
    bus.IMemData = dat(bus.IMemAddr);
  endtask

  task automatic clear_branch();
    bus.Branch = 1'b0; bus.Unconditional = 1'b0; bus.ALUZero = 1'b0; bus.ZorNZ = 1'b0;
    bus.BranchTarget = 64'h0;
  endtask

  // Leaves the DUT one cycle after reset release: first request at RESET_PC outstanding.
  task automatic do_reset();
    rst = 1'b1;
    clear_branch();
    bus.IMemAck = 1'b0; bus.IMemData = 32'h0; bus.InstrReady = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_branch();
    bus.IMemAck = 1'b0; bus.IMemData = 32'h0; bus.InstrReady = 1'b0;
    cyc();
    vecs++; if (bus.PC !== 64'h0) begin errs++; $display("FAIL reset_pc act=%h exp=%h", bus.PC, 64'h0); end
    vecs++; if (bus.IMemReq !== 1'b0) begin errs++; $display("FAIL reset_req act=%b exp=0", bus.IMemReq); end
    vecs++; if (bus.IMemAddr !== 64'h0) begin errs++; $display("FAIL reset_addr act=%h exp=0", bus.IMemAddr); end
    vecs++; if (bus.InstrValid !== 1'b0) begin errs++; $display("FAIL reset_valid act=%b exp=0", bus.InstrValid); end
    vecs++; if (bus.Instr !== 32'h0 || bus.InstrPC !== 64'h0) begin errs++; $display("FAIL reset_head act=%h/%h exp=0/0", bus.Instr, bus.InstrPC); end
    vecs++; if (bus.Redirect !== 1'b0 || bus.Fault !== 1'b0) begin errs++; $display("FAIL reset_flags act=%b%b exp=00", bus.Redirect, bus.Fault); end
    rst = 1'b0;
    cyc();
    vecs++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 64'h0) begin errs++; $display("FAIL first_req act=%b/%h exp=1/0", bus.IMemReq, bus.IMemAddr); end
  endtask

  task automatic test_stream();
    logic [63:0] a;
    bus.InstrReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 64'(i) * 64'd4;
      mem_drive(1'b1);
      cyc();
      vecs++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== a) begin errs++; $display("FAIL stream_pc[%0d] act=%b/%h exp=1/%h", i, bus.InstrValid, bus.InstrPC, a); end
      vecs++; if (bus.Instr !== dat(a)) begin errs++; $display("FAIL stream_instr[%0d] act=%h exp=%h", i, bus.Instr, dat(a)); end
      vecs++; if (bus.IMemAddr !== a + 64'd4 || bus.PC !== a + 64'd4) begin errs++; $display("FAIL stream_addr[%0d] act=%h/%h exp=%h", i, bus.IMemAddr, bus.PC, a + 64'd4); end
    end
    bus.IMemAck = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_drive(1'b1); cyc();
    mem_drive(1'b1); cyc();
    vecs++; if (bus.IMemReq !== 1'b0 || bus.PC !== 64'h8) begin errs++; $display("FAIL full_stop act=%b/%h exp=0/8", bus.IMemReq, bus.PC); end
    mem_drive(1'b1);
    bus.IMemAck = 1'b1;
    cyc(); cyc();
    vecs++; if (bus.IMemReq !== 1'b0 || bus.InstrPC !== 64'h0 || bus.PC !== 64'h8) begin errs++; $display("FAIL full_hold act=%b/%h/%h exp=0/0/8", bus.IMemReq, bus.InstrPC, bus.PC); end
    bus.IMemAck = 1'b0;
    bus.InstrReady = 1'b1;
    cyc();
    vecs++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 64'h8 || bus.InstrPC !== 64'h4) begin errs++; $display("FAIL resume act=%b/%h/%h exp=1/8/4", bus.IMemReq, bus.IMemAddr, bus.InstrPC); end
    mem_drive(1'b1); cyc();
    vecs++; if (bus.InstrPC !== 64'h8 || bus.Instr !== dat(64'h8) || bus.PC !== 64'hC) begin errs++; $display("FAIL resume_data act=%h/%h exp=8/c", bus.InstrPC, bus.PC); end
    bus.IMemAck = 1'b0;
  endtask

  task automatic test_branch_drain();
    do_reset();
    mem_drive(1'b1); cyc();
    bus.IMemAck = 1'b0;
    bus.Branch = 1'b1; bus.ALUZero = 1'b1; bus.ZorNZ = 1'b1; bus.BranchTarget = 64'h100;
    cyc();
    clear_branch();
    vecs++; if (bus.PC !== 64'h100 || bus.Redirect !== 1'b1) begin errs++; $display("FAIL drain_pc act=%h/%b exp=100/1", bus.PC, bus.Redirect); end
    vecs++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 64'h4 || bus.InstrValid !== 1'b0) begin errs++; $display("FAIL drain_hold act=%b/%h/%b exp=1/4/0", bus.IMemReq, bus.IMemAddr, bus.InstrValid); end
    cyc(); cyc();
    vecs++; if (bus.Redirect !== 1'b0 || bus.IMemAddr !== 64'h4) begin errs++; $display("FAIL drain_wait act=%b/%h exp=0/4", bus.Redirect, bus.IMemAddr); end
    mem_drive(1'b1); cyc();
    vecs++; if (bus.IMemAddr !== 64'h100 || bus.InstrValid !== 1'b0 || bus.IMemReq !== 1'b1) begin errs++; $display("FAIL drain_discard act=%h/%b exp=100/0", bus.IMemAddr, bus.InstrValid); end
    bus.InstrReady = 1'b1;
    mem_drive(1'b1); cyc();
    vecs++; if (bus.InstrPC !== 64'h100 || bus.Instr !== dat(64'h100) || bus.PC !== 64'h104) begin errs++; $display("FAIL drain_target act=%h/%h exp=100/104", bus.InstrPC, bus.PC); end
    bus.IMemAck = 1'b0;
  endtask

  task automatic test_not_taken_and_jump();
    do_reset();
    bus.InstrReady = 1'b1;
    bus.Branch = 1'b1; bus.ALUZero = 1'b1; bus.ZorNZ = 1'b0; bus.BranchTarget = 64'h300;
    mem_drive(1'b1); cyc();
    clear_branch();
    vecs++; if (bus.InstrPC !== 64'h0 || bus.IMemAddr !== 64'h4 || bus.Redirect !== 1'b0) begin errs++; $display("FAIL not_taken act=%h/%h/%b exp=0/4/0", bus.InstrPC, bus.IMemAddr, bus.Redirect); end
    mem_drive(1'b1); cyc();
    bus.Unconditional = 1'b1; bus.BranchTarget = 64'h200;
    mem_drive(1'b1); cyc();
    clear_branch();
    vecs++; if (bus.PC !== 64'h200 || bus.IMemAddr !== 64'h200 || bus.IMemReq !== 1'b1) begin errs++; $display("FAIL jump_collide act=%h/%h exp=200/200", bus.PC, bus.IMemAddr); end
    vecs++; if (bus.InstrValid !== 1'b0 || bus.Redirect !== 1'b1) begin errs++; $display("FAIL jump_flush act=%b/%b exp=0/1", bus.InstrValid, bus.Redirect); end
    mem_drive(1'b1); cyc();
    vecs++; if (bus.InstrPC !== 64'h200 || bus.IMemAddr !== 64'h204 || bus.Redirect !== 1'b0) begin errs++; $display("FAIL jump_fetch act=%h/%h/%b exp=200/204/0", bus.InstrPC, bus.IMemAddr, bus.Redirect); end
    bus.IMemAck = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_drive(1'b1); cyc();
    bus.IMemAck = 1'b0;
    vecs++; if (bus.InstrValid !== 1'b1 || bus.IMemAddr !== 64'h4) begin errs++; $display("FAIL mid_setup act=%b/%h exp=1/4", bus.InstrValid, bus.IMemAddr); end
    #1 rst = 1'b1;
    #1;
    vecs++; if (bus.IMemReq !== 1'b0 || bus.IMemAddr !== 64'h0 || bus.PC !== 64'h0) begin errs++; $display("FAIL mid_reset_req act=%b/%h/%h exp=0/0/0", bus.IMemReq, bus.IMemAddr, bus.PC); end
    vecs++; if (bus.InstrValid !== 1'b0 || bus.Instr !== 32'h0 || bus.InstrPC !== 64'h0) begin errs++; $display("FAIL mid_reset_head act=%b/%h/%h exp=0/0/0", bus.InstrValid, bus.Instr, bus.InstrPC); end
    rst = 1'b0;
    cyc();
    vecs++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 64'h0 || bus.InstrValid !== 1'b0) begin errs++; $display("FAIL mid_restart act=%b/%h/%b exp=1/0/0", bus.IMemReq, bus.IMemAddr, bus.InstrValid); end
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.InstrReady = 1'b1;
    bus.Unconditional = 1'b1; bus.BranchTarget = 64'h102;
    cyc();
    clear_branch();
`ifdef PC_ALIGN_CHECK_EN
    vecs++; if (bus.Fault !== 1'b1 || bus.PC !== 64'h0) begin errs++; $display("FAIL mis_fault act=%b/%h exp=1/0", bus.Fault, bus.PC); end
    bus.IMemAck = 1'b1;
    cyc();
    bus.IMemAck = 1'b0;
    cyc(); cyc();
    vecs++; if (bus.IMemReq !== 1'b0 || bus.Fault !== 1'b1 || bus.InstrValid !== 1'b0) begin errs++; $display("FAIL mis_halt act=%b/%b exp=0/1", bus.IMemReq, bus.Fault); end
`else
    vecs++; if (bus.Fault !== 1'b0 || bus.PC !== 64'h100 || bus.IMemAddr !== 64'h0) begin errs++; $display("FAIL mis_pc act=%b/%h/%h exp=0/100/0", bus.Fault, bus.PC, bus.IMemAddr); end
    bus.IMemAck = 1'b1;
    cyc();
    bus.IMemAck = 1'b0;
    vecs++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 64'h100) begin errs++; $display("FAIL mis_fetch act=%b/%h exp=1/100", bus.IMemReq, bus.IMemAddr); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_drain();
    test_not_taken_and_jump();
    test_reset_mid();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
